// File: rtl/ram_port_arbiter_pkg.sv
// Shared encodings for the data-RAM port arbiter: FSM states and requester owner ids.
package ram_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_CMD  = 2'b01;
  localparam logic [1:0] ARB_RSP  = 2'b10;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr2.sv
// Two-way round-robin pick: grant bit 0 = IFU, bit 1 = LSU; ties go to whoever did not own last.
module arb_rr2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // NOTE: grant_o gets a default before any branch so this block never infers a latch.
  always_comb begin
    grant_o = 2'b00;
    if (req_i == 2'b11) begin
      grant_o = (last_i == OWN_LSU) ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single data-RAM port between IFU and LSU: round-robin, one transaction in
// flight, and an LSU lock that holds the grant across a read-modify-write sequence.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter bit          LSU_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req_valid,
  input  logic [AW-1:0] ifu_req_addr,
  output logic          ifu_req_ready,
  output logic          ifu_rsp_valid,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          lsu_req_valid,
  input  logic          lsu_req_wr,
  input  logic [AW-1:0] lsu_req_addr,
  input  logic [DW-1:0] lsu_req_wdata,
  input  logic          lsu_req_lock,
  output logic          lsu_req_ready,
  output logic          lsu_rsp_valid,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          ram_valid,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic          ram_ready,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic LAST_RST = LSU_FIRST ? OWN_IFU : OWN_LSU;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q;
  logic          lock_q, lock_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    eligible;
  logic [1:0]    grant;
  logic          in_idle;
  logic          in_rsp;
  logic          accept;

  // A held lock makes the IFU ineligible so the LSU keeps the port for its RMW.
  assign eligible = {lsu_req_valid, ifu_req_valid & ~lock_q};

  arb_rr2 u_rr2 (
    .req_i   (eligible),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign in_idle = (state_q == ARB_IDLE);
  assign in_rsp  = (state_q == ARB_RSP);
  assign accept  = in_idle & (|grant);

  assign ifu_req_ready = in_idle & grant[0];
  assign lsu_req_ready = in_idle & grant[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (accept)    state_d = ARB_CMD;
      ARB_CMD:  if (ram_ready) state_d = ARB_RSP;
      ARB_RSP:                 state_d = ARB_IDLE;
      default:                 state_d = ARB_IDLE;
    endcase
  end

  assign owner_d = grant[1] ? OWN_LSU : OWN_IFU;
  assign lock_d  = grant[1] & lsu_req_lock;
  assign wr_d    = grant[1] & lsu_req_wr;
  assign addr_d  = grant[1] ? lsu_req_addr : ifu_req_addr;
  assign wdata_d = grant[1] ? lsu_req_wdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IFU;
      last_q  <= LAST_RST;
      lock_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= owner_d;
        last_q  <= owner_d;
        lock_q  <= lock_d;
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
      end
    end
  end

  // The command registers only load on accept, so the RAM sees a stable command while stalled.
  assign ram_valid = (state_q == ARB_CMD);
  assign ram_wr    = ram_valid & wr_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign ifu_rsp_valid = in_rsp & (owner_q == OWN_IFU);
  assign lsu_rsp_valid = in_rsp & (owner_q == OWN_LSU);
  assign ifu_rsp_rdata = ifu_rsp_valid ? ram_rdata : '0;
  assign lsu_rsp_rdata = (lsu_rsp_valid & ~wr_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model that also plays the RAM.
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_wr;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic        lsu_req_lock;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_rdata;
  logic        ram_valid;
  logic        ram_wr;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ready;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.AW(32), .DW(32), .LSU_FIRST(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_req_ready (ifu_req_ready),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_rdata (ifu_rsp_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_wr    (lsu_req_wr),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_lock  (lsu_req_lock),
    .lsu_req_ready (lsu_req_ready),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_rdata (lsu_rsp_rdata),
    .ram_valid     (ram_valid),
    .ram_wr        (ram_wr),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_ready     (ram_ready),
    .ram_rdata     (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge, where inputs may change.
  task automatic edge_in();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_wr    = 1'b0;
    lsu_req_lock  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drop_reqs();
    ifu_req_addr  = '0;
    lsu_req_addr  = '0;
    lsu_req_wdata = '0;
    ram_ready     = 1'b0;
    ram_rdata     = 32'hFFFF_FFFF;
    edge_in();
    edge_in();
    @(negedge clk);
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {ifu_req_ready, lsu_req_ready}); end
    checks++; if ({ram_valid, ram_wr, ifu_rsp_valid, lsu_rsp_valid} !== 4'b0000) begin errors++; $display("FAIL reset_valids: got %b expected 0000", {ram_valid, ram_wr, ifu_rsp_valid, lsu_rsp_valid}); end
    checks++; if ({ram_addr, ram_wdata, ifu_rsp_rdata, lsu_rsp_rdata} !== 128'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {ram_addr, ram_wdata, ifu_rsp_rdata, lsu_rsp_rdata}); end
  endtask

  task automatic test_ifu_read();
    edge_in();
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h10;
    ram_ready     = 1'b1;
    ram_rdata     = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({ifu_req_ready, lsu_req_ready, ram_valid} !== 3'b100) begin errors++; $display("FAIL t1_accept: got ready/ready/valid %b expected 100", {ifu_req_ready, lsu_req_ready, ram_valid}); end
    edge_in();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({ram_valid, ram_wr, ifu_req_ready} !== 3'b100) begin errors++; $display("FAIL t1_cmd: got valid/wr/ready %b expected 100", {ram_valid, ram_wr, ifu_req_ready}); end
    checks++; if (ram_addr !== 32'h10) begin errors++; $display("FAIL t1_addr: got %h expected 00000010", ram_addr); end
    edge_in();
    @(negedge clk);
    checks++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b10) begin errors++; $display("FAIL t1_rsp_valid: got %b expected 10", {ifu_rsp_valid, lsu_rsp_valid}); end
    checks++; if (ifu_rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_rsp_data: got %h expected deadbeef", ifu_rsp_rdata); end
    edge_in();
    @(negedge clk);
    checks++; if (ifu_rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_rsp_pulse: got %b expected 0", ifu_rsp_valid); end
  endtask

  task automatic test_alternation();
    logic [31:0] rd;
    int n;
    bit exp_lsu;
    edge_in();
    rst = 1'b1;
    edge_in();
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h100;
    lsu_req_valid = 1'b1;
    lsu_req_wr    = 1'b0;
    lsu_req_addr  = 32'h200;
    lsu_req_lock  = 1'b0;
    ram_ready     = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(ifu_req_ready || lsu_req_ready) && n < 8) begin
        edge_in();
        @(negedge clk);
        n++;
      end
      checks++; if (n >= 8) begin errors++; $display("FAIL t2_grant_timeout: got no ready in %0d cycles expected a grant", n); end
      exp_lsu = (i % 2 == 0);
      checks++; if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin errors++; $display("FAIL t2_grant%0d: got ifu/lsu %b expected %b", i, {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu}); end
      rd = 32'h1000 + 32'(i);
      edge_in();
      ram_rdata = rd;
      @(negedge clk);
      checks++; if (ram_valid !== 1'b1 || ram_addr !== (exp_lsu ? 32'h200 : 32'h100)) begin errors++; $display("FAIL t2_cmd%0d: got valid %b addr %h", i, ram_valid, ram_addr); end
      edge_in();
      @(negedge clk);
      checks++; if ({ifu_rsp_valid, lsu_rsp_valid} !== {~exp_lsu, exp_lsu}) begin errors++; $display("FAIL t2_rsp_owner%0d: got ifu/lsu %b expected %b", i, {ifu_rsp_valid, lsu_rsp_valid}, {~exp_lsu, exp_lsu}); end
      checks++; if ((exp_lsu ? lsu_rsp_rdata : ifu_rsp_rdata) !== rd) begin errors++; $display("FAIL t2_rsp_data%0d: got %h expected %h", i, exp_lsu ? lsu_rsp_rdata : ifu_rsp_rdata, rd); end
      edge_in();
      if (i == 3) drop_reqs();
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    edge_in();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h40;
    lsu_req_valid = 1'b1;
    lsu_req_wr    = 1'b0;
    lsu_req_addr  = 32'h20;
    lsu_req_lock  = 1'b1;
    ram_ready     = 1'b1;
    @(negedge clk);
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin errors++; $display("FAIL t3_lock_read_grant: got %b expected 01", {ifu_req_ready, lsu_req_ready}); end
    edge_in();
    lsu_req_valid = 1'b0;
    ram_rdata     = 32'h5555_AAAA;
    @(negedge clk);
    edge_in();
    @(negedge clk);
    checks++; if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL t3_read_rsp: got %b/%h expected 1/5555aaaa", lsu_rsp_valid, lsu_rsp_rdata); end
    for (int k = 0; k < 2; k++) begin
      edge_in();
      @(negedge clk);
      checks++; if (ifu_req_ready !== 1'b0) begin errors++; $display("FAIL t3_ifu_starve%0d: got %b expected 0", k, ifu_req_ready); end
    end
    edge_in();
    lsu_req_valid = 1'b1;
    lsu_req_wr    = 1'b1;
    lsu_req_wdata = 32'h1234_5678;
    lsu_req_lock  = 1'b0;
    @(negedge clk);
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin errors++; $display("FAIL t3_write_grant: got %b expected 01", {ifu_req_ready, lsu_req_ready}); end
    edge_in();
    lsu_req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({ram_valid, ram_wr, ifu_req_ready} !== 3'b110 || ram_addr !== 32'h20 || ram_wdata !== 32'h1234_5678) begin errors++; $display("FAIL t3_write_cmd: got %b %h %h", {ram_valid, ram_wr, ifu_req_ready}, ram_addr, ram_wdata); end
    edge_in();
    @(negedge clk);
    checks++; if ({lsu_rsp_valid, ifu_req_ready} !== 2'b10 || lsu_rsp_rdata !== 32'h0) begin errors++; $display("FAIL t3_write_rsp: got %b %h expected 10 0", {lsu_rsp_valid, ifu_req_ready}, lsu_rsp_rdata); end
    edge_in();
    @(negedge clk);
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin errors++; $display("FAIL t3_ifu_after_unlock: got %b expected 10", {ifu_req_ready, lsu_req_ready}); end
    edge_in();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    edge_in();
    @(negedge clk);
    checks++; if (ifu_rsp_valid !== 1'b1) begin errors++; $display("FAIL t3_ifu_rsp: got %b expected 1", ifu_rsp_valid); end
  endtask

  task automatic test_stall();
    int pulses;
    edge_in();
    lsu_req_valid = 1'b1;
    lsu_req_wr    = 1'b1;
    lsu_req_addr  = 32'h33;
    lsu_req_wdata = 32'hCAFE_F00D;
    lsu_req_lock  = 1'b0;
    ram_ready     = 1'b0;
    @(negedge clk);
    checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL t4_accept: got %b expected 1", lsu_req_ready); end
    for (int k = 0; k < 6; k++) begin
      edge_in();
      lsu_req_valid = 1'b0;
      lsu_req_addr  = $urandom;
      lsu_req_wdata = $urandom;
      ram_ready     = (k == 5);
      @(negedge clk);
      checks++; if (ram_valid !== 1'b1 || ram_addr !== 32'h33 || ram_wdata !== 32'hCAFE_F00D || (ifu_rsp_valid | lsu_rsp_valid) !== 1'b0) begin errors++; $display("FAIL t4_stable%0d: got %b %h %h rsp %b", k, ram_valid, ram_addr, ram_wdata, ifu_rsp_valid | lsu_rsp_valid); end
    end
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      edge_in();
      @(negedge clk);
      if (ifu_rsp_valid || lsu_rsp_valid) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL t4_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_lsu_write();
    edge_in();
    lsu_req_valid = 1'b1;
    lsu_req_wr    = 1'b1;
    lsu_req_addr  = 32'h44;
    lsu_req_wdata = 32'hA5A5_A5A5;
    ram_ready     = 1'b1;
    ram_rdata     = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("FAIL t5_accept: got %b expected 1", lsu_req_ready); end
    edge_in();
    lsu_req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({ram_valid, ram_wr} !== 2'b11 || ram_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL t5_cmd: got %b %h expected 11 a5a5a5a5", {ram_valid, ram_wr}, ram_wdata); end
    edge_in();
    @(negedge clk);
    checks++; if (lsu_rsp_valid !== 1'b1 || lsu_rsp_rdata !== 32'h0) begin errors++; $display("FAIL t5_ack: got %b %h expected 1 00000000", lsu_rsp_valid, lsu_rsp_rdata); end
    edge_in();
    lsu_req_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    edge_in();
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h50;
    ram_ready     = 1'b0;
    @(negedge clk);
    edge_in();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (ram_valid !== 1'b1) begin errors++; $display("FAIL t6_in_cmd: got %b expected 1", ram_valid); end
    edge_in();
    rst = 1'b1;
    @(negedge clk);
    edge_in();
    rst = 1'b0;
    ram_ready = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h60;
    @(negedge clk);
    checks++; if ({ram_valid, ifu_rsp_valid, lsu_rsp_valid} !== 3'b000) begin errors++; $display("FAIL t6_cmd_reset: got %b expected 000", {ram_valid, ifu_rsp_valid, lsu_rsp_valid}); end
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL t6_fresh_grant: got %b expected 1", ifu_req_ready); end
    edge_in();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (ram_valid !== 1'b1 || ram_addr !== 32'h60) begin errors++; $display("FAIL t6_fresh_cmd: got %b %h expected 1 00000060", ram_valid, ram_addr); end
    edge_in();
    @(negedge clk);
    edge_in();
    lsu_req_valid = 1'b1;
    lsu_req_wr    = 1'b0;
    lsu_req_addr  = 32'h70;
    lsu_req_lock  = 1'b1;
    @(negedge clk);
    edge_in();
    drop_reqs();
    @(negedge clk);
    edge_in();
    rst = 1'b1;
    @(negedge clk);
    edge_in();
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h80;
    @(negedge clk);
    checks++; if ({ram_valid, ifu_rsp_valid, lsu_rsp_valid} !== 3'b000) begin errors++; $display("FAIL t6_rsp_reset: got %b expected 000", {ram_valid, ifu_rsp_valid, lsu_rsp_valid}); end
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL t6_lock_cleared: got %b expected 1", ifu_req_ready); end
    edge_in();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    edge_in();
    @(negedge clk);
  endtask

  // Transaction-level model: phase 0 = free, 1 = command pending at RAM, 2 = response due.
  task automatic test_random();
    logic [31:0] mem [8];
    logic [31:0] m_addr, m_wdata, m_rd;
    int  ph;
    bit  m_own, m_wr, m_last, m_lock, ie, le, exp_i, exp_l;
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    ph = 0; m_last = 1'b0; m_lock = 1'b0; m_own = 1'b0; m_wr = 1'b0;
    m_addr = '0; m_wdata = '0; m_rd = '0;
    edge_in();
    rst = 1'b1;
    drop_reqs();
    for (int c = 0; c < 600; c++) begin
      edge_in();
      rst = 1'b0;
      ifu_req_valid = ($urandom_range(0, 9) < 6);
      ifu_req_addr  = $urandom_range(0, 7);
      lsu_req_valid = ($urandom_range(0, 1) == 1);
      lsu_req_wr    = ($urandom_range(0, 1) == 1);
      lsu_req_addr  = $urandom_range(0, 7);
      lsu_req_wdata = $urandom;
      lsu_req_lock  = ($urandom_range(0, 3) == 0);
      ram_ready     = ($urandom_range(0, 9) < 7);
      ram_rdata     = (ph == 2 && !m_wr) ? m_rd : $urandom;
      @(negedge clk);
      ie = ifu_req_valid && !m_lock;
      le = lsu_req_valid;
      exp_i = 1'b0; exp_l = 1'b0;
      if (ph == 0) begin
        if (ie && le) begin
          exp_i = m_last;
          exp_l = !m_last;
        end else begin
          exp_i = ie;
          exp_l = le;
        end
      end
      checks++; if ({ifu_req_ready, lsu_req_ready} !== {exp_i, exp_l}) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, {ifu_req_ready, lsu_req_ready}, {exp_i, exp_l}); end
      checks++; if (ram_valid !== (ph == 1)) begin errors++; $display("FAIL rnd_ram_valid c%0d: got %b expected %b", c, ram_valid, ph == 1); end
      if (ph == 1) begin
        checks++; if (ram_addr !== m_addr || ram_wr !== m_wr || (m_wr && ram_wdata !== m_wdata)) begin errors++; $display("FAIL rnd_cmd c%0d: got %h %b %h expected %h %b %h", c, ram_addr, ram_wr, ram_wdata, m_addr, m_wr, m_wdata); end
      end
      checks++; if ({ifu_rsp_valid, lsu_rsp_valid} !== {ph == 2 && !m_own, ph == 2 && m_own}) begin errors++; $display("FAIL rnd_rsp_valid c%0d: got %b expected %b", c, {ifu_rsp_valid, lsu_rsp_valid}, {ph == 2 && !m_own, ph == 2 && m_own}); end
      if (ph == 2) begin
        checks++; if ((m_own ? lsu_rsp_rdata : ifu_rsp_rdata) !== (m_wr ? 32'h0 : m_rd)) begin errors++; $display("FAIL rnd_rsp_data c%0d: got %h expected %h", c, m_own ? lsu_rsp_rdata : ifu_rsp_rdata, m_wr ? 32'h0 : m_rd); end
      end
      if (ph == 0 && (exp_i || exp_l)) begin
        m_own   = exp_l;
        m_last  = exp_l;
        m_lock  = exp_l && lsu_req_lock;
        m_wr    = exp_l && lsu_req_wr;
        m_addr  = exp_l ? lsu_req_addr : ifu_req_addr;
        m_wdata = lsu_req_wdata;
        ph = 1;
      end else if (ph == 1 && ram_ready) begin
        if (m_wr) mem[m_addr[2:0]] = m_wdata;
        else      m_rd = mem[m_addr[2:0]];
        ph = 2;
      end else if (ph == 2) begin
        ph = 0;
      end
    end
    edge_in();
    drop_reqs();
    ram_ready = 1'b1;
    repeat (4) edge_in();
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_alternation();
    test_lock();
    test_stall();
    test_lsu_write();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
